// File: rtl/reg_bank_2w_pkg.sv
// Shared CPU register-file constants, used by the register bank and the read-mux stage.
package reg_bank_2w_pkg;

  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ZERO_REG   = 0;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_bank_sb.sv
// Pending-write scoreboard: one busy bit per register, set by issue-slot allocs,
// cleared by writebacks; a same-cycle alloc outranks a clear.
module reg_bank_sb
  import reg_bank_2w_pkg::*;
#(
  parameter int ZERO_HARD = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc0,
  input  logic [REG_ADDR_W-1:0] alloc_addr0,
  input  logic                alloc1,
  input  logic [REG_ADDR_W-1:0] alloc_addr1,
  input  logic                we0,
  input  logic [REG_ADDR_W-1:0] waddr0,
  input  logic                we1,
  input  logic [REG_ADDR_W-1:0] waddr1,
  output logic [NUM_REGS-1:0] busy
);

  logic [NUM_REGS-1:0] busy_reg;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_mask
    localparam reg_addr_t IDX = REG_ADDR_W'(gi);
    localparam bit SETTABLE = !((ZERO_HARD != 0) && (gi == ZERO_REG));
    // Two slots hitting one address simply OR into a single set.
    assign set_mask[gi] = SETTABLE && ((alloc0 && (alloc_addr0 == IDX)) ||
                                       (alloc1 && (alloc_addr1 == IDX)));
    assign clr_mask[gi] = (we0 && (waddr0 == IDX)) || (we1 && (waddr1 == IDX));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= (busy_reg & ~clr_mask) | set_mask;
    end
  end

  assign busy = busy_reg;

endmodule

// File: rtl/reg_bank_2w.sv
// 32-entry register bank with two writeback ports (port 1 younger) and an optional
// pending-write scoreboard enabled by macro REG_BANK_SCOREBOARD_EN.
module reg_bank_2w
  import reg_bank_2w_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ZERO_HARD = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic [REG_ADDR_W-1:0]      waddr0,
  input  logic [DATA_W-1:0]          wdata0,
  input  logic                       we1,
  input  logic [REG_ADDR_W-1:0]      waddr1,
  input  logic [DATA_W-1:0]          wdata1,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  input  logic                       alloc0,
  input  logic [REG_ADDR_W-1:0]      alloc_addr0,
  input  logic                       alloc1,
  input  logic [REG_ADDR_W-1:0]      alloc_addr1,
  output logic [NUM_REGS-1:0]        busy
);

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
    localparam reg_addr_t IDX = REG_ADDR_W'(gi);
    localparam bit HARD_ZERO = (ZERO_HARD != 0) && (gi == ZERO_REG);
    logic [DATA_W-1:0] data_reg;

    // Port 1 is checked first so the younger slot wins a same-address collision.
    always_ff @(posedge clk) begin
      if (rst || HARD_ZERO) begin
        data_reg <= '0;
      end else if (we1 && (waddr1 == IDX)) begin
        data_reg <= wdata1;
      end else if (we0 && (waddr0 == IDX)) begin
        data_reg <= wdata0;
      end
    end

    assign regs_flat[gi*DATA_W +: DATA_W] = data_reg;
  end

`ifdef REG_BANK_SCOREBOARD_EN
  reg_bank_sb #(
    .ZERO_HARD(ZERO_HARD)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .alloc0     (alloc0),
    .alloc_addr0(alloc_addr0),
    .alloc1     (alloc1),
    .alloc_addr1(alloc_addr1),
    .we0        (we0),
    .waddr0     (waddr0),
    .we1        (we1),
    .waddr1     (waddr1),
    .busy       (busy)
  );
`else
  logic unused_alloc;
  assign unused_alloc = ^{alloc0, alloc_addr0, alloc1, alloc_addr1};
  assign busy = '0;
`endif

endmodule

// File: tb/tb_reg_bank_2w.sv
// Bench for reg_bank_2w: two instances (ZERO_HARD=1 and ZERO_HARD=0) share stimulus,
// a sequential-semantics model is compared every cycle, plus literal spot checks.
module tb_reg_bank_2w;
  localparam int DW = 32;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;
  logic we0, we1, alloc0, alloc1;
  logic [4:0] waddr0, waddr1, alloc_addr0, alloc_addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [NR*DW-1:0] regs_h, regs_nz;
  logic [NR-1:0] busy_h, busy_nz;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  reg_bank_2w #(.DATA_W(DW), .ZERO_HARD(1)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .regs_flat(regs_h),
    .alloc0(alloc0), .alloc_addr0(alloc_addr0),
    .alloc1(alloc1), .alloc_addr1(alloc_addr1),
    .busy(busy_h)
  );

  reg_bank_2w #(.DATA_W(DW), .ZERO_HARD(0)) dut_nz (
    .clk(clk), .rst(rst),
    .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
    .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
    .regs_flat(regs_nz),
    .alloc0(alloc0), .alloc_addr0(alloc_addr0),
    .alloc1(alloc1), .alloc_addr1(alloc_addr1),
    .busy(busy_nz)
  );

  // Model: apply slot 0 then slot 1 in program order; later writes overwrite earlier.
  logic [DW-1:0] m_h [NR];
  logic [DW-1:0] m_nz[NR];
  bit [NR-1:0] mb_h, mb_nz;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_h[i] = '0;
        m_nz[i] = '0;
      end
      mb_h = '0;
      mb_nz = '0;
    end else begin
      if (we0) begin m_h[waddr0] = wdata0; m_nz[waddr0] = wdata0; end
      if (we1) begin m_h[waddr1] = wdata1; m_nz[waddr1] = wdata1; end
      m_h[0] = '0;
`ifdef REG_BANK_SCOREBOARD_EN
      if (we0) begin mb_h[waddr0] = 1'b0; mb_nz[waddr0] = 1'b0; end
      if (we1) begin mb_h[waddr1] = 1'b0; mb_nz[waddr1] = 1'b0; end
      if (alloc0) begin mb_nz[alloc_addr0] = 1'b1; if (alloc_addr0 != 0) mb_h[alloc_addr0] = 1'b1; end
      if (alloc1) begin mb_nz[alloc_addr1] = 1'b1; if (alloc_addr1 != 0) mb_h[alloc_addr1] = 1'b1; end
`endif
    end
  end

  task automatic cmp_regs(input string name, input logic [NR*DW-1:0] act, input logic [DW-1:0] m[NR]);
    int bad;
    bad = -1;
    for (int i = NR - 1; i >= 0; i--)
      if (act[i*DW +: DW] !== m[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s reg[%0d] got %h expected %h", name, bad, act[bad*DW +: DW], m[bad]);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp_regs("regs_zh1", regs_h, m_h);
      cmp_regs("regs_zh0", regs_nz, m_nz);
      tests += 2;
      if (busy_h !== mb_h) begin
        fails++;
        $display("FAIL busy_zh1 got %h expected %h", busy_h, mb_h);
      end
      if (busy_nz !== mb_nz) begin
        fails++;
        $display("FAIL busy_zh0 got %h expected %h", busy_nz, mb_nz);
      end
    end
  end

  task automatic idle();
    we0 = 0; we1 = 0; alloc0 = 0; alloc1 = 0;
    waddr0 = 0; waddr1 = 0; alloc_addr0 = 0; alloc_addr1 = 0;
    wdata0 = 0; wdata1 = 0;
  endtask

  // Advance one clock and return at the following falling edge, outputs settled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
    $display("[TB] %s = %h", name, act);
  endtask

  initial begin
    idle();
    rst = 1;
    @(negedge clk);
    step();
    cmp_en = 1'b1;
    rst = 0;
    lit("reset_busy", 32'(busy_h), 32'h0);
    lit("reset_reg31", regs_h[31*DW +: DW], 32'h0);

    // Reset then write
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step(); idle();
    lit("wr_reg5", regs_h[5*DW +: DW], 32'hDEADBEEF);
    lit("wr_reg4", regs_h[4*DW +: DW], 32'h0);
    lit("wr_reg6", regs_h[6*DW +: DW], 32'h0);

    // Dual-write collision
    we0 = 1; waddr0 = 9; wdata0 = 32'h11111111;
    we1 = 1; waddr1 = 9; wdata1 = 32'h22222222;
    step(); idle();
    lit("collide_reg9", regs_h[9*DW +: DW], 32'h22222222);

    // Zero register
    we1 = 1; waddr1 = 0; wdata1 = 32'hFFFFFFFF;
    step(); idle();
    lit("zero_hard1_reg0", regs_h[0 +: DW], 32'h0);
    lit("zero_hard0_reg0", regs_nz[0 +: DW], 32'hFFFFFFFF);

    // Scoreboard set / set-beats-clear / clear
    alloc0 = 1; alloc_addr0 = 3;
    step(); idle();
`ifdef REG_BANK_SCOREBOARD_EN
    lit("sb_alloc_busy3", 32'(busy_h[3]), 32'h1);
`else
    lit("sb_off_busy", 32'(busy_h), 32'h0);
`endif
    we0 = 1; waddr0 = 3; wdata0 = 32'h33; alloc1 = 1; alloc_addr1 = 3;
    step(); idle();
`ifdef REG_BANK_SCOREBOARD_EN
    lit("sb_setwins_busy3", 32'(busy_h[3]), 32'h1);
`endif
    we0 = 1; waddr0 = 3; wdata0 = 32'h34;
    step(); idle();
    lit("sb_clear_busy3", 32'(busy_h[3]), 32'h0);
    lit("sb_clear_reg3", regs_h[3*DW +: DW], 32'h34);

    // Reset mid-operation
    we0 = 1; waddr0 = 1; wdata0 = 32'hAAAA0001;
    we1 = 1; waddr1 = 2; wdata1 = 32'hBBBB0002;
    alloc0 = 1; alloc_addr0 = 4;
    step(); idle();
    lit("mid_reg1", regs_h[1*DW +: DW], 32'hAAAA0001);
`ifdef REG_BANK_SCOREBOARD_EN
    lit("mid_busy4", 32'(busy_h[4]), 32'h1);
`endif
    rst = 1; we0 = 1; waddr0 = 1; wdata0 = 32'h55555555; alloc1 = 1; alloc_addr1 = 7;
    step(); idle(); rst = 0;
    lit("rst_reg1", regs_h[1*DW +: DW], 32'h0);
    lit("rst_reg2", regs_nz[2*DW +: DW], 32'h0);
    lit("rst_busy", 32'(busy_nz), 32'h0);

    // Allocs to 1..31 across both slots, then an alloc to 0
    for (int a = 1; a < NR; a++) begin
      alloc0 = 1; alloc_addr0 = 5'(a);
      alloc1 = 1; alloc_addr1 = 5'(a);
      step();
    end
    idle();
    alloc0 = 1; alloc_addr0 = 0;
    step(); idle();
`ifdef REG_BANK_SCOREBOARD_EN
    lit("allocs_busy_zh1", 32'(busy_h), 32'hFFFFFFFE);
    lit("allocs_busy_zh0", 32'(busy_nz), 32'hFFFFFFFF);
`else
    lit("allocs_busy_off", 32'(busy_h), 32'h0);
`endif
    we0 = 1; waddr0 = 5; wdata0 = 32'hDEADBEEF;
    step(); idle();
    lit("after_allocs_reg5", regs_h[5*DW +: DW], 32'hDEADBEEF);

    // Mixed traffic with occasional reset
    for (int n = 0; n < 60; n++) begin
      rst = ($urandom_range(0, 19) == 0);
      we0 = 1'($urandom); waddr0 = 5'($urandom_range(0, 7)); wdata0 = $urandom;
      we1 = 1'($urandom); waddr1 = 5'($urandom_range(0, 7)); wdata1 = $urandom;
      alloc0 = 1'($urandom); alloc_addr0 = 5'($urandom_range(0, 7));
      alloc1 = 1'($urandom); alloc_addr1 = 5'($urandom_range(0, 7));
      step();
    end
    rst = 0; idle();
    step();
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
